// File: rtl/ecc_result_collector.sv
// Result capture FIFO behind the ECC top: show-ahead valid/ready drain,
// saturating per-class error statistics and a sticky overflow flag.
module ecc_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          operation_done,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic [1:0]                    num_of_errors,
    input  logic                          clr_stats,
    input  logic                          res_ready,
    output logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [1:0]                    res_errors,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          cnt_err0,
    output logic [CNT_WIDTH-1:0]          cnt_err1,
    output logic [CNT_WIDTH-1:0]          cnt_err2,
    output logic [CNT_WIDTH-1:0]          cnt_drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [1:0]            mem_err  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  do_write;
    logic                  drop;

    assign res_valid  = (fifo_count != '0);
    assign res_data   = mem_data[rd_ptr];
    assign res_errors = mem_err[rd_ptr];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign full     = (fifo_count == FULL_COUNT);
    assign pop      = res_valid & res_ready;
    assign do_write = operation_done & (~full | pop);
    assign drop     = operation_done & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= '0;
            end
        end else if (do_write) begin
            mem_data[wr_ptr] <= data_in;
            mem_err[wr_ptr]  <= num_of_errors;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Statistics count every completed operation, stored or dropped; clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_err0 <= '0;
            cnt_err1 <= '0;
            cnt_err2 <= '0;
            cnt_drop <= '0;
            overflow <= 1'b0;
        end else if (clr_stats) begin
            cnt_err0 <= '0;
            cnt_err1 <= '0;
            cnt_err2 <= '0;
            cnt_drop <= '0;
            overflow <= 1'b0;
        end else begin
            if (operation_done) begin
                case (num_of_errors)
                    2'b00:   if (cnt_err0 != '1) cnt_err0 <= cnt_err0 + 1'b1;
                    2'b01:   if (cnt_err1 != '1) cnt_err1 <= cnt_err1 + 1'b1;
                    2'b10:   if (cnt_err2 != '1) cnt_err2 <= cnt_err2 + 1'b1;
                    default: ;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
                if (cnt_drop != '1) cnt_drop <= cnt_drop + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_result_collector.sv
// Scoreboard bench for ecc_result_collector: driver pushes expected entries,
// a negedge monitor pops and compares every accepted FIFO head.
module tb_ecc_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        operation_done = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  num_of_errors = '0;
    logic        clr_stats = 1'b0;
    logic        res_ready = 1'b0;

    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_errors;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] cnt_err0, cnt_err1, cnt_err2, cnt_drop;

    logic        s_valid;
    logic [31:0] s_data;
    logic [1:0]  s_errors;
    logic [2:0]  s_count;
    logic        s_overflow;
    logic [3:0]  s_err0, s_err1, s_err2, s_drop;

    int checks = 0;
    int failures = 0;

    int model_count = 0;
    int m_err0 = 0, m_err1 = 0, m_err2 = 0, m_drop = 0;
    bit m_ovf = 1'b0;
    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_err_q[$];

    always #5 clk = ~clk;

    ecc_result_collector dut (
        .clk(clk), .rst(rst), .operation_done(operation_done), .data_in(data_in),
        .num_of_errors(num_of_errors), .clr_stats(clr_stats), .res_ready(res_ready),
        .res_valid(res_valid), .res_data(res_data), .res_errors(res_errors),
        .fifo_count(fifo_count), .overflow(overflow), .cnt_err0(cnt_err0),
        .cnt_err1(cnt_err1), .cnt_err2(cnt_err2), .cnt_drop(cnt_drop)
    );

    ecc_result_collector #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .operation_done(operation_done), .data_in(data_in),
        .num_of_errors(num_of_errors), .clr_stats(clr_stats), .res_ready(res_ready),
        .res_valid(s_valid), .res_data(s_data), .res_errors(s_errors),
        .fifo_count(s_count), .overflow(s_overflow), .cnt_err0(s_err0),
        .cnt_err1(s_err1), .cnt_err2(s_err2), .cnt_drop(s_drop)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_count"}, fifo_count, model_count);
        check({tag, "_valid"}, res_valid, model_count != 0);
        check({tag, "_overflow"}, overflow, m_ovf);
        check({tag, "_err0"}, cnt_err0, m_err0);
        check({tag, "_err1"}, cnt_err1, m_err1);
        check({tag, "_err2"}, cnt_err2, m_err2);
        check({tag, "_drop"}, cnt_drop, m_drop);
        if (model_count != 0 && exp_data_q.size() != 0) begin
            check({tag, "_head_data"}, res_data, exp_data_q[0]);
            check({tag, "_head_err"}, res_errors, exp_err_q[0]);
        end
    endtask

    // Drives one cycle of inputs and advances the model to the state after that edge.
    task automatic applyStimulus(input bit op, input logic [31:0] data, input logic [1:0] err,
                                 input bit ready, input bit clr);
        bit pop;
        bit wrote;
        operation_done = op;
        data_in = data;
        num_of_errors = err;
        res_ready = ready;
        clr_stats = clr;
        pop = (model_count != 0) && ready;
        wrote = 1'b0;
        if (op) begin
            if (model_count == 4 && !pop) begin
                m_ovf = 1'b1;
                m_drop++;
            end else begin
                exp_data_q.push_back(data);
                exp_err_q.push_back(err);
                wrote = 1'b1;
            end
            if (err == 2'b00) m_err0++;
            if (err == 2'b01) m_err1++;
            if (err == 2'b10) m_err2++;
        end
        if (clr) begin
            m_err0 = 0; m_err1 = 0; m_err2 = 0; m_drop = 0; m_ovf = 1'b0;
        end
        model_count = model_count + int'(wrote) - int'(pop);
        @(posedge clk);
        #1;
        operation_done = 1'b0;
        clr_stats = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic resetDut(input string tag);
        rst = 1'b0;
        #1;
        exp_data_q.delete();
        exp_err_q.delete();
        model_count = 0;
        m_err0 = 0; m_err1 = 0; m_err2 = 0; m_drop = 0; m_ovf = 1'b0;
        checkOutput(tag);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_errors"}, res_errors, 0);
        check({tag, "_small_err1"}, s_err1, 0);
        check({tag, "_small_count"}, s_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst && res_valid && res_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL pop_unexpected actual_data=0x%0h expected=no_entry", res_data);
                end else begin
                    check("pop_data", res_data, exp_data_q.pop_front());
                    check("pop_err", res_errors, exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] fill_vals [4];
        fill_vals[0] = 32'hA0; fill_vals[1] = 32'hA1;
        fill_vals[2] = 32'hA2; fill_vals[3] = 32'hA3;
        @(posedge clk);
        #1;
        resetDut("reset");

        $display("[TB] scenario 1: single result");
        applyStimulus(1, 32'h0000_00A5, 2'b00, 0, 0);
        checkOutput("s1_push");
        check("s1_data", res_data, 32'hA5);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s1_pop");

        $display("[TB] scenario 2: fill and overflow");
        for (int i = 0; i < 4; i++) applyStimulus(1, fill_vals[i], 2'(i), 0, 0);
        checkOutput("s2_full");
        applyStimulus(1, 32'hDEAD_BEEF, 2'b01, 0, 0);
        checkOutput("s2_drop");
        check("s2_drop_cnt", cnt_drop, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s2_drained");

        $display("[TB] scenario 3: push and pop on full");
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'hB0 + 32'(i), 2'b10, 0, 0);
        applyStimulus(1, 32'hB4, 2'b00, 1, 0);
        checkOutput("s3_swap");
        check("s3_head", res_data, 32'hB1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s3_drained");

        $display("[TB] scenario 4: streaming");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 32'hC000 + 32'(i), 2'(i % 3), 1, 0);
            checkOutput("s4_stream");
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s4_drained");

        $display("[TB] scenario 5: saturation and clear");
        resetDut("s5_reset");
        for (int i = 0; i < 20; i++) applyStimulus(1, 32'h5000 + 32'(i), 2'b01, 1, 0);
        checkOutput("s5_counted");
        check("s5_small_sat", s_err1, 15);
        applyStimulus(1, 32'h5555, 2'b01, 1, 1);
        checkOutput("s5_clear");
        check("s5_small_clr", s_err1, 0);
        check("s5_small_ovf", s_overflow, 0);
        check("s5_small_count", s_count, 1);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] scenario 6: reset mid-stream");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h6000 + 32'(i), 2'b10, 0, 0);
        checkOutput("s6_queued");
        resetDut("s6_reset");
        applyStimulus(1, 32'h0000_00A5, 2'b00, 0, 0);
        checkOutput("s6_push");
        check("s6_data", res_data, 32'hA5);
        check("s6_err0", cnt_err0, 1);

        for (int i = 0; i < 8 && model_count != 0; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("final");
        check("final_queue_empty", exp_data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
